// File: rtl/config_master_if.sv
// Config bus bundle between the packet side, the config master and the register responder.
// Carries the command stream (valid/ready), the read-response stream (valid/ready) and the config strobes.
// master: config_master view; slave: packet source / response sink / responder view.
interface config_master_if #(
    parameter int CDW = 21,
    parameter int CAW = 15,
    parameter int OPW = 2
);
    localparam int PKT_W = OPW + CAW + CDW;
    localparam int RSP_W = CAW + CDW;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [PKT_W-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RSP_W-1:0] rsp_data;
    logic             config_we;
    logic [CAW-1:0]   config_waddr;
    logic [CDW-1:0]   config_wdata;
    logic             config_re;
    logic [CAW-1:0]   config_raddr;
    logic [CDW-1:0]   config_rdata;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, config_rdata,
        output cmd_ready, rsp_valid, rsp_data,
        output config_we, config_waddr, config_wdata, config_re, config_raddr
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, config_rdata,
        input  cmd_ready, rsp_valid, rsp_data,
        input  config_we, config_waddr, config_wdata, config_re, config_raddr
    );
endinterface

// File: rtl/config_master.sv
// Executes config command packets as single-beat writes/reads on the config bus, returns read data as responses.
// Latency: write strobe 1 cycle after accept; read response valid 3 cycles after accept.
// Backpressure: cmd_ready only in IDLE; a response is held stable until rsp_ready, blocking new commands.
// Ports: clk, rst_n (async active-low), bus (config_master_if.master: cmd/rsp streams + config strobes),
//        wr_cnt/rd_cnt/drop_cnt (saturating event counters), busy (not IDLE).
module config_master #(
    parameter int CDW = 21,
    parameter int CAW = 15,
    parameter int OPW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    config_master_if.master bus,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt,
    output logic [15:0] drop_cnt,
    output logic        busy
);
    localparam int PKT_W = OPW + CAW + CDW;

    localparam logic [OPW-1:0] OP_WRITE = OPW'(1);
    localparam logic [OPW-1:0] OP_READ  = OPW'(2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RW   = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t state;

    logic [OPW-1:0] cmd_op;
    logic [CAW-1:0] cmd_addr;
    logic [CDW-1:0] cmd_wdata;
    logic           accept;

    assign cmd_op    = bus.cmd_data[PKT_W-1 -: OPW];
    assign cmd_addr  = bus.cmd_data[CDW +: CAW];
    assign cmd_wdata = bus.cmd_data[CDW-1:0];

    // Gated with rst_n so ready reads 0 while reset is held, not just after it.
    assign bus.cmd_ready = (state == IDLE) && rst_n;
    assign busy          = (state != IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_data     <= '0;
            bus.config_we    <= 1'b0;
            bus.config_waddr <= '0;
            bus.config_wdata <= '0;
            bus.config_re    <= 1'b0;
            bus.config_raddr <= '0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            drop_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_WRITE) begin
                            // Strobe and payload are loaded together so they appear in the WR cycle.
                            bus.config_we    <= 1'b1;
                            bus.config_waddr <= cmd_addr;
                            bus.config_wdata <= cmd_wdata;
                            state            <= WR;
                        end else if (cmd_op == OP_READ) begin
                            bus.config_re    <= 1'b1;
                            bus.config_raddr <= cmd_addr;
                            state            <= RD;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end
                WR: begin
                    bus.config_we <= 1'b0;
                    wr_cnt        <= sat_inc(wr_cnt);
                    state         <= IDLE;
                end
                RD: begin
                    bus.config_re <= 1'b0;
                    state         <= RW;
                end
                RW: begin
                    // Responder data for the RD-cycle address is valid now; raddr is still held.
                    bus.rsp_data  <= {bus.config_raddr, bus.config_rdata};
                    bus.rsp_valid <= 1'b1;
                    state         <= RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rd_cnt        <= sat_inc(rd_cnt);
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.config_we <= 1'b0;
                    bus.config_re <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/config_master.md
Name: config_master

Overview:
- Initiator side of the node configuration bus: accepts configuration command packets from the node's packet input, executes them as single-beat write or read transactions on the config bus, and returns read data as response packets.
- Sits between the router/packet ingress and the node's configuration register/memory responder.
- The responder has one-cycle read latency: read data is valid in the cycle after config_re, selected by the address presented together with config_re.

Parameters:
CDW, 21, config data width
CAW, 15, config address width
OPW, 2, command opcode width
PKT_W, OPW+CAW+CDW (38), command packet width
RSP_W, CAW+CDW (36), response packet width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command packet valid
cmd_ready  output  1  command packet accepted when valid&ready
cmd_data  input  PKT_W  {op[OPW-1:0], addr[CAW-1:0], data[CDW-1:0]}
rsp_valid  output  1  read response valid
rsp_ready  input  1  downstream accepts response
rsp_data  output  RSP_W  {addr[CAW-1:0], rdata[CDW-1:0]}
config_we  output  1  config write strobe, one cycle
config_waddr  output  CAW  config write address
config_wdata  output  CDW  config write data
config_re  output  1  config read strobe, one cycle
config_raddr  output  CAW  config read address
config_rdata  input  CDW  read data, valid the cycle after config_re
wr_cnt  output  16  completed writes, saturating
rd_cnt  output  16  completed read responses, saturating
drop_cnt  output  16  dropped NOP/illegal commands, saturating
busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low; every output is 0 (cmd_ready, rsp_valid, rsp_data, config_*, counters, busy); state = IDLE.
- All outputs are registered except:
  - cmd_ready = (state == IDLE);
  - busy = (state != IDLE).
- Opcodes:
  - 2'b01 = WRITE;
  - 2'b10 = READ;
  - 2'b00 and 2'b11 = dropped. drop_cnt increments on acceptance, no bus activity, state stays IDLE.
- IDLE, on cmd_valid & cmd_ready (cycle 0): latch addr and data.
  - WRITE -> state WR.
  - READ -> state RD.
- WR (cycle 1):
  - config_we = 1, config_waddr = latched addr, config_wdata = latched data.
  - wr_cnt increments; next state IDLE.
  - config_we is high exactly one cycle per write.
- RD (cycle 1):
  - config_re = 1, config_raddr = latched addr.
  - Next state RW.
- RW (cycle 2):
  - config_re = 0; config_raddr held.
  - config_rdata is sampled at the end of this cycle into rsp_data = {addr, config_rdata}.
  - Next state RSP.
- RSP (cycle 3 onward):
  - rsp_valid = 1; rsp_data is stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle, rd_cnt increments, state -> IDLE.
  - rsp_ready asserted in the first RSP cycle gives a one-cycle response.
- Throughput:
  - writes: 1 per 2 cycles;
  - reads: 1 per 4 cycles minimum.
- Commands are not accepted while a response is pending; ordering is strict.
- config_waddr/config_wdata/config_raddr hold their last values when idle. Only the strobes qualify them.
- Unmapped address types are passed through unchanged. The responder's filler data (0x0EEEEE pattern for CDW=21) is returned as-is and is not an error.
- Counters saturate at 16'hFFFF; they do not wrap.
- rsp_ready high outside RSP has no effect.
- cmd_data is ignored when cmd_ready = 0.
- Reset asserted mid-transaction:
  - immediate return to IDLE;
  - pending response discarded;
  - strobes and rsp_valid forced to 0 asynchronously.
- States: IDLE, WR, RD, RW, RSP.
- Any unused encoding recovers to IDLE next cycle.

Test Plan:
1. Write: cmd {01, 15'h000A, 21'h00123} with rsp_ready=1 -> cycle 1 shows config_we=1, waddr=0x000A, wdata=0x00123 for exactly one cycle; wr_cnt=1; no rsp_valid.
2. Read with model responder (1-cycle latency, returns 0x0ABCD for addr 0x1005) -> config_re=1 with raddr=0x1005 in cycle 1; rsp_valid rises in cycle 3 with rsp_data={0x1005, 0x0ABCD}; rd_cnt=1.
3. Backpressure: read as in scenario 2 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable; cmd_ready=0 throughout; second command stays pending and is accepted the cycle after IDLE returns.
4. Opcodes 00 and 11 presented back-to-back -> both accepted, drop_cnt=2, config_we/config_re never asserted, cmd_ready stays 1.
5. Stream of 4 writes followed by 1 read to the same address (responder echoes the last write, 0x1FFFFF) -> 4 single-cycle we pulses 2 cycles apart; response data 0x1FFFFF; wr_cnt=4, rd_cnt=1.
6. rst_n low during RW of a read -> all outputs 0 immediately; after release: IDLE, cmd_ready=1, no spurious rsp_valid, counters 0.
